// File: rtl/ysyx_23060124_scoreboard.sv
// Issue-side hazard scoreboard: per-register in-flight write counters gating IDU issue.
// Optional `SCOREBOARD_PERF_EN adds the stall_cycles performance counter output.
module ysyx_23060124_scoreboard #(
   parameter int unsigned NREG = 16,
   parameter int unsigned CNTW = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             idu_valid,
   output logic             idu_ready,
   input  logic [3:0]       idu_rs1,
   input  logic [3:0]       idu_rs2,
   input  logic             idu_rs1_en,
   input  logic             idu_rs2_en,
   input  logic             idu_wen,
   input  logic [3:0]       idu_rd,
   input  logic             exu_wen,
   input  logic [3:0]       exu_rd,
   input  logic             wbu_wen,
   input  logic [3:0]       wbu_rd,
   input  logic             commit_wen,
   input  logic [3:0]       commit_rd,
   output logic [NREG-1:0]  busy_mask,
   output logic             sb_err
`ifdef SCOREBOARD_PERF_EN
   ,
   output logic [31:0]      stall_cycles
`endif
);

   localparam logic [CNTW-1:0] CNT_MAX = '1;
   localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

   logic [CNTW-1:0] cnt     [NREG];
   logic [CNTW-1:0] cnt_nxt [NREG];
   logic            rs1_blk;
   logic            rs2_blk;
   logic            rd_blk;
   logic            fire;
   logic            err_set;

   // A single outstanding writer is only usable if its result is on a forwarding bus now.
   function automatic logic src_blocked(input logic en, input logic [3:0] rs,
                                        input logic [CNTW-1:0] c,
                                        input logic ew, input logic [3:0] erd,
                                        input logic ww, input logic [3:0] wrd);
      logic blk;
      blk = 1'b0;
      if (en && rs != '0) begin
         if (c > CNT_ONE)
            blk = 1'b1;
         else if (c == CNT_ONE)
            blk = !((ew && erd == rs) || (ww && wrd == rs));
      end
      return blk;
   endfunction

   always_comb begin
      rs1_blk = src_blocked(idu_rs1_en, idu_rs1, cnt[idu_rs1], exu_wen, exu_rd, wbu_wen, wbu_rd);
      rs2_blk = src_blocked(idu_rs2_en, idu_rs2, cnt[idu_rs2], exu_wen, exu_rd, wbu_wen, wbu_rd);
      rd_blk  = idu_wen && idu_rd != '0 && cnt[idu_rd] == CNT_MAX &&
                !(commit_wen && commit_rd == idu_rd);
   end

   assign idu_ready = !(rs1_blk || rs2_blk || rd_blk);
   assign fire      = idu_valid && idu_ready;

   always_comb begin
      err_set = 1'b0;
      for (int unsigned r = 0; r < NREG; r++) begin
         logic inc;
         logic dec;
         cnt_nxt[r] = cnt[r];
         inc = (r != 0) && fire && idu_wen && idu_rd == 4'(r);
         dec = (r != 0) && commit_wen && commit_rd == 4'(r);
         if (dec && cnt[r] == '0)
            err_set = 1'b1;
         if (inc && !dec)
            cnt_nxt[r] = cnt[r] + CNT_ONE;
         else if (dec && !inc && cnt[r] != '0)
            cnt_nxt[r] = cnt[r] - CNT_ONE;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int unsigned r = 0; r < NREG; r++)
            cnt[r] <= '0;
         sb_err <= 1'b0;
      end else begin
         for (int unsigned r = 0; r < NREG; r++)
            cnt[r] <= cnt_nxt[r];
         if (err_set)
            sb_err <= 1'b1;
      end
   end

   always_comb begin
      busy_mask = '0;
      for (int unsigned r = 1; r < NREG; r++)
         busy_mask[r] = cnt[r] != '0;
   end

`ifdef SCOREBOARD_PERF_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         stall_cycles <= '0;
      else if (idu_valid && !idu_ready)
         stall_cycles <= stall_cycles + 32'd1;
   end
`endif

endmodule

// File: tb/tb_ysyx_23060124_scoreboard.sv
// Directed, table-driven bench for ysyx_23060124_scoreboard (covers `SCOREBOARD_PERF_EN when defined).
module tb_ysyx_23060124_scoreboard;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        idu_valid = 1'b0, idu_ready;
   logic [3:0]  idu_rs1 = '0, idu_rs2 = '0, idu_rd = '0;
   logic        idu_rs1_en = 1'b0, idu_rs2_en = 1'b0, idu_wen = 1'b0;
   logic        exu_wen = 1'b0, wbu_wen = 1'b0, commit_wen = 1'b0;
   logic [3:0]  exu_rd = '0, wbu_rd = '0, commit_rd = '0;
   logic [15:0] busy_mask;
   logic        sb_err;
`ifdef SCOREBOARD_PERF_EN
   logic [31:0] stall_cycles;
`endif

   int checks = 0;
   int failures = 0;

   always #5 clock = ~clock;

   ysyx_23060124_scoreboard #(.NREG(16), .CNTW(2)) dut (
      .clock(clock), .reset(reset),
      .idu_valid(idu_valid), .idu_ready(idu_ready),
      .idu_rs1(idu_rs1), .idu_rs2(idu_rs2),
      .idu_rs1_en(idu_rs1_en), .idu_rs2_en(idu_rs2_en),
      .idu_wen(idu_wen), .idu_rd(idu_rd),
      .exu_wen(exu_wen), .exu_rd(exu_rd),
      .wbu_wen(wbu_wen), .wbu_rd(wbu_rd),
      .commit_wen(commit_wen), .commit_rd(commit_rd),
      .busy_mask(busy_mask), .sb_err(sb_err)
`ifdef SCOREBOARD_PERF_EN
      , .stall_cycles(stall_cycles)
`endif
   );

   typedef struct {
      logic       valid;
      logic       rs1_en; logic [3:0] rs1;
      logic       rs2_en; logic [3:0] rs2;
      logic       wen;    logic [3:0] rd;
      logic       ew;     logic [3:0] erd;
      logic       ww;     logic [3:0] wrd;
      logic       cw;     logic [3:0] crd;
      logic       exp_ready;
      logic [15:0] exp_busy;
      logic       exp_err;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(logic v, logic r1e, logic [3:0] r1, logic r2e, logic [3:0] r2,
                               logic w, logic [3:0] rd, logic ew, logic [3:0] erd,
                               logic ww, logic [3:0] wrd, logic cw, logic [3:0] crd,
                               logic er, logic [15:0] eb, logic ee);
      vec_t t;
      t.valid = v; t.rs1_en = r1e; t.rs1 = r1; t.rs2_en = r2e; t.rs2 = r2;
      t.wen = w; t.rd = rd; t.ew = ew; t.erd = erd; t.ww = ww; t.wrd = wrd;
      t.cw = cw; t.crd = crd; t.exp_ready = er; t.exp_busy = eb; t.exp_err = ee;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      idu_valid = 0; idu_rs1_en = 0; idu_rs1 = 0; idu_rs2_en = 0; idu_rs2 = 0;
      idu_wen = 0; idu_rd = 0; exu_wen = 0; exu_rd = 0; wbu_wen = 0; wbu_rd = 0;
      commit_wen = 0; commit_rd = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 0;
      repeat (2) @(posedge clock);
      #1 reset = 1;
   endtask

   // Inputs applied, combinational ready and pre-edge state checked, then one clock edge.
   task automatic apply(input int idx, input vec_t t);
      idu_valid = t.valid; idu_rs1_en = t.rs1_en; idu_rs1 = t.rs1;
      idu_rs2_en = t.rs2_en; idu_rs2 = t.rs2; idu_wen = t.wen; idu_rd = t.rd;
      exu_wen = t.ew; exu_rd = t.erd; wbu_wen = t.ww; wbu_rd = t.wrd;
      commit_wen = t.cw; commit_rd = t.crd;
      #1;
      chk($sformatf("v%0d.idu_ready", idx), 32'(idu_ready), 32'(t.exp_ready));
      chk($sformatf("v%0d.busy_mask", idx), 32'(busy_mask), 32'(t.exp_busy));
      chk($sformatf("v%0d.sb_err", idx), 32'(sb_err), 32'(t.exp_err));
      @(posedge clock);
      #1;
   endtask

   initial begin
      //          v  r1e r1 r2e r2 w  rd ew erd ww wrd cw crd  rdy busy     err
      vq.push_back(mk(1, 1, 5, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0,  1, 16'h0000, 0)); // 0 idle sources
      vq.push_back(mk(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0,  1, 16'h0000, 0)); // 1 issue load rd3
      vq.push_back(mk(0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 16'h0008, 0)); // 2 blocked, valid=0
      vq.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 16'h0008, 0)); // 3 blocked
      vq.push_back(mk(1, 1, 3, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0,  1, 16'h0008, 0)); // 4 exu fwd
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3,  1, 16'h0008, 0)); // 5 commit rd3
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 16'h0000, 0)); // 6 rd3 cleared
      vq.push_back(mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0,  1, 16'h0000, 0)); // 7 rd7 #1
      vq.push_back(mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0,  1, 16'h0080, 0)); // 8 rd7 #2
      vq.push_back(mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0,  1, 16'h0080, 0)); // 9 rd7 #3
      vq.push_back(mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0,  0, 16'h0080, 0)); // 10 rd at max
      vq.push_back(mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 1, 7,  1, 16'h0080, 0)); // 11 same-cycle commit
      vq.push_back(mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0,  0, 16'h0080, 0)); // 12 count stayed 3
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7,  1, 16'h0080, 0)); // 13
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7,  1, 16'h0080, 0)); // 14
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7,  1, 16'h0080, 0)); // 15
      vq.push_back(mk(1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0,  1, 16'h0000, 0)); // 16 rd4 #1
      vq.push_back(mk(1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0,  1, 16'h0010, 0)); // 17 rd4 #2
      vq.push_back(mk(1, 0, 0, 1, 4, 0, 0, 1, 4, 0, 0, 0, 0,  0, 16'h0010, 0)); // 18 cnt2 + exu fwd
      vq.push_back(mk(1, 0, 0, 1, 4, 0, 0, 0, 0, 1, 4, 0, 0,  0, 16'h0010, 0)); // 19 cnt2 + wbu fwd
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4,  1, 16'h0010, 0)); // 20 commit rd4
      vq.push_back(mk(1, 1, 4, 0, 0, 0, 0, 0, 0, 1, 4, 1, 4,  1, 16'h0010, 0)); // 21 commit+read, wbu fwd
      vq.push_back(mk(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0,  1, 16'h0000, 0)); // 22 x0 everywhere
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 16'h0000, 0)); // 23 commit x0
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9,  1, 16'h0000, 0)); // 24 underflow rd9
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 16'h0000, 1)); // 25 err set
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 16'h0000, 1)); // 26 err sticky

      do_reset();
      chk("reset.idu_ready", 32'(idu_ready), 32'd1);
      chk("reset.busy_mask", 32'(busy_mask), 32'd0);
      chk("reset.sb_err", 32'(sb_err), 32'd0);
`ifdef SCOREBOARD_PERF_EN
      chk("reset.stall_cycles", stall_cycles, 32'd0);
`endif

      foreach (vq[i]) apply(i, vq[i]);

      // Commit to x0 straight out of reset must not flag an error.
      do_reset();
      idle_inputs();
      commit_wen = 1; commit_rd = 0;
      repeat (2) @(posedge clock);
      #1 idle_inputs();
      chk("x0_commit.sb_err", 32'(sb_err), 32'd0);

      // Long stall on a pending load, then asynchronous reset mid-stall.
      do_reset();
      idu_valid = 1; idu_wen = 1; idu_rd = 2;
      @(posedge clock);
      #1 idle_inputs();
      idu_valid = 1; idu_rs1_en = 1; idu_rs1 = 2;
      #1 chk("stall.idu_ready", 32'(idu_ready), 32'd0);
      repeat (10) @(posedge clock);
      #1;
      chk("stall.busy_mask", 32'(busy_mask), 32'h0004);
`ifdef SCOREBOARD_PERF_EN
      chk("stall.stall_cycles", stall_cycles, 32'd10);
`endif
      #2 reset = 0;
      #1;
      chk("midrst.busy_mask", 32'(busy_mask), 32'd0);
      chk("midrst.idu_ready", 32'(idu_ready), 32'd1);
      chk("midrst.sb_err", 32'(sb_err), 32'd0);
`ifdef SCOREBOARD_PERF_EN
      chk("midrst.stall_cycles", stall_cycles, 32'd0);
`endif
      idle_inputs();
      @(posedge clock);
      #1 reset = 1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
